rr_arbiter_n: RTL and testbench

- Parametrised N-input round-robin arbiter with valid/ready handshakes on every port; merges NUM_IN source streams onto one sink stream.
- Adds three features: a registered output stage at full throughput, optional packet locking on a last flag, and a source-index sideband.
- Sits wherever multiple requesters share one downstream channel (bus masters to a shared FIFO or link).

---
 rtl/rr_arb_pkg.sv | 36 +++
 rtl/rr_grant_select.sv | 28 ++
 rtl/rr_arbiter_n.sv | 71 +++++++
 tb/tb_rr_arbiter_n.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared helpers for round-robin arbiters: modulo-N index wrap and a rotating
// first-set search that starts at a pointer.
package rr_arb_pkg;
    localparam int MAX_N = 32;
    localparam int IW    = 5;

    typedef logic [IW-1:0] idx_t;

    typedef struct packed {
        logic vld;
        idx_t idx;
    } grant_t;

    // The wrap is an explicit compare against n-1, so non-power-of-2 counts work.
    function automatic idx_t next_idx(input idx_t idx, input logic [IW:0] n);
        return (idx == IW'(n - 1'b1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic grant_t rr_first(input logic [MAX_N-1:0] req, input idx_t ptr,
                                        input logic [IW:0] n);
        grant_t g;
        idx_t   idx;
        g   = '0;
        idx = ptr;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < int'(n)) begin
                if (!g.vld && req[idx]) begin
                    g.vld = 1'b1;
                    g.idx = idx;
                end
                idx = next_idx(idx, n);
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/rr_grant_select.sv
// Combinational rotating priority encoder; a held lock overrides the search.
module rr_grant_select
    import rr_arb_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SW     = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SW-1:0]     ptr,
    input  logic              lock,
    input  logic [SW-1:0]     lock_idx,
    output logic              grant_valid,
    output logic [SW-1:0]     grant_idx
);
    grant_t rr;

    always_comb begin
        rr = rr_first(MAX_N'(req), IW'(ptr), (IW+1)'(NUM_IN));
        // While locked only the owner may move; its ready follows its own valid.
        if (lock) begin
            grant_valid = req[lock_idx];
            grant_idx   = lock_idx;
        end else begin
            grant_valid = rr.vld;
            grant_idx   = SW'(rr.idx);
        end
    end
endmodule

// File: rtl/rr_arbiter_n.sv
// N-input round-robin arbiter with a registered output stage, optional
// packet locking on t_last, and a source-index sideband.
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter  int DWIDTH       = 32,
    parameter  int NUM_IN       = 4,
    parameter  int LOCK_ON_LAST = 1,
    localparam int SW           = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rstf,
    input  logic [NUM_IN*DWIDTH-1:0] t_data,
    input  logic [NUM_IN-1:0]        t_valid,
    input  logic [NUM_IN-1:0]        t_last,
    output logic [NUM_IN-1:0]        t_ready,
    output logic [DWIDTH-1:0]        i0_data,
    output logic                     i0_last,
    output logic [SW-1:0]            i0_src,
    output logic                     i0_valid,
    input  logic                     i0_ready
);
    logic [SW-1:0] ptr, lock_idx, gidx, ptr_nxt;
    logic          locked, gvld, accept, xfer;

    rr_grant_select #(.NUM_IN(NUM_IN)) u_sel (
        .req        (t_valid),
        .ptr        (ptr),
        .lock       (locked),
        .lock_idx   (lock_idx),
        .grant_valid(gvld),
        .grant_idx  (gidx)
    );

    // Output register refills in the same cycle it drains, so no bubbles.
    assign accept  = ~i0_valid | i0_ready;
    assign xfer    = accept & gvld;
    assign t_ready = xfer ? (NUM_IN'(1) << gidx) : '0;
    assign ptr_nxt = SW'(next_idx(IW'(gidx), (IW+1)'(NUM_IN)));

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            i0_valid <= 1'b0;
            i0_data  <= '0;
            i0_last  <= 1'b0;
            i0_src   <= '0;
            ptr      <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (accept) begin
                i0_valid <= xfer;
                if (xfer) begin
                    i0_data <= t_data[gidx*DWIDTH +: DWIDTH];
                    i0_last <= t_last[gidx];
                    i0_src  <= gidx;
                end
            end
            // Pointer moves past the channel actually granted, not past ptr.
            if (xfer) begin
                if (LOCK_ON_LAST == 0 || t_last[gidx]) begin
                    locked <= 1'b0;
                    ptr    <= ptr_nxt;
                end else begin
                    locked   <= 1'b1;
                    lock_idx <= gidx;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: three configurations (4/no-lock, 4/lock, 3/no-lock)
// driven from one vector table, with a beat scoreboard on the output side.
module tb_rr_arbiter_n;
    logic         clk = 1'b0;
    logic         rstf = 1'b0;
    logic [127:0] td  [3];
    logic [3:0]   tv  [3];
    logic [3:0]   tl  [3];
    logic         rdy [3];

    logic [3:0]  tr0, tr1;
    logic [2:0]  tr2;
    logic [31:0] od0, od1, od2;
    logic        ol0, ol1, ol2, ov0, ov1, ov2;
    logic [1:0]  os0, os1, os2;

    logic [3:0]  trv [3];
    logic [31:0] odv [3];
    logic        olv [3];
    logic        ovv [3];
    logic [1:0]  osv [3];

    always #5 clk = ~clk;

    rr_arbiter_n #(.DWIDTH(32), .NUM_IN(4), .LOCK_ON_LAST(0)) dut0 (
        .clk(clk), .rstf(rstf), .t_data(td[0]), .t_valid(tv[0]), .t_last(tl[0]),
        .t_ready(tr0), .i0_data(od0), .i0_last(ol0), .i0_src(os0), .i0_valid(ov0),
        .i0_ready(rdy[0]));
    rr_arbiter_n #(.DWIDTH(32), .NUM_IN(4), .LOCK_ON_LAST(1)) dut1 (
        .clk(clk), .rstf(rstf), .t_data(td[1]), .t_valid(tv[1]), .t_last(tl[1]),
        .t_ready(tr1), .i0_data(od1), .i0_last(ol1), .i0_src(os1), .i0_valid(ov1),
        .i0_ready(rdy[1]));
    rr_arbiter_n #(.DWIDTH(32), .NUM_IN(3), .LOCK_ON_LAST(0)) dut2 (
        .clk(clk), .rstf(rstf), .t_data(td[2][95:0]), .t_valid(tv[2][2:0]), .t_last(tl[2][2:0]),
        .t_ready(tr2), .i0_data(od2), .i0_last(ol2), .i0_src(os2), .i0_valid(ov2),
        .i0_ready(rdy[2]));

    always_comb begin
        trv[0] = tr0; trv[1] = tr1; trv[2] = {1'b0, tr2};
        odv[0] = od0; odv[1] = od1; odv[2] = od2;
        olv[0] = ol0; olv[1] = ol1; olv[2] = ol2;
        ovv[0] = ov0; ovv[1] = ov1; ovv[2] = ov2;
        osv[0] = os0; osv[1] = os1; osv[2] = os2;
    end

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int         c;
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic [3:0] etr;
    } vec_t;

    beat_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    function automatic logic [31:0] dat(input int c, input int k, input int n);
        return {8'(c), 8'(k), 16'(n)};
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d step%0d: got %h want %h", name, c, cyc, act, exp);
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input int c, input logic [3:0] v, input logic [3:0] l,
                        input logic r, input logic [3:0] etr);
        beat_t b;
        cyc++;
        tv[c] = v; tl[c] = l; rdy[c] = r;
        for (int k = 0; k < 4; k++) td[c][k*32 +: 32] = dat(c, k, cyc);
        #1;
        chk("t_ready", c, 32'(trv[c]), 32'(etr));
        chk("i0_valid", c, 32'(ovv[c]), 32'(q.size() != 0));
        if (ovv[c] && q.size() != 0) begin
            chk("i0_src", c, 32'(osv[c]), 32'(q[0].src));
            chk("i0_data", c, odv[c], q[0].data);
            chk("i0_last", c, 32'(olv[c]), 32'(q[0].last));
            if (r) void'(q.pop_front());
        end
        if ((etr & v) != 4'b0) begin
            for (int k = 0; k < 4; k++)
                if (etr[k]) begin
                    b.src  = 2'(k);
                    b.data = dat(c, k, cyc);
                    b.last = l[k];
                end
            q.push_back(b);
        end
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        for (int c = 0; c < 3; c++) begin
            tv[c] = '0; tl[c] = '0; rdy[c] = 1'b0; td[c] = '0;
        end

        // cfg0: N=4, no lock.  Full rotation, then 1010 from ptr=0, backpressure.
        for (int i = 0; i < 8; i++)
            vecs.push_back('{0, 4'hF, 4'hF, 1'b1, 4'(1 << (i % 4))});
        vecs.push_back('{0, 4'b1010, 4'hF, 1'b1, 4'b0010});
        vecs.push_back('{0, 4'b1010, 4'hF, 1'b1, 4'b1000});
        vecs.push_back('{0, 4'b1010, 4'hF, 1'b1, 4'b0010});
        vecs.push_back('{0, 4'b1010, 4'hF, 1'b1, 4'b1000});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0100, 4'h4, 1'b1, 4'b0100});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{0, 4'hF, 4'hF, 1'b0, 4'b0000});
        vecs.push_back('{0, 4'hF, 4'hF, 1'b1, 4'b1000});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0001, 4'h1, 1'b0, 4'b0001});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b0, 4'b0000});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b1, 4'b0000});
        vecs.push_back('{0, 4'b0000, 4'h0, 1'b1, 4'b0000});

        // cfg1: N=4, lock on last.  Ch2 3-beat packet with a 2-cycle gap; ch0 waits.
        vecs.push_back('{1, 4'b0010, 4'b0010, 1'b1, 4'b0010});
        vecs.push_back('{1, 4'b0101, 4'b0000, 1'b1, 4'b0100});
        vecs.push_back('{1, 4'b0101, 4'b0000, 1'b1, 4'b0100});
        vecs.push_back('{1, 4'b0001, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{1, 4'b0001, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{1, 4'b0101, 4'b0100, 1'b1, 4'b0100});
        vecs.push_back('{1, 4'b1001, 4'b1001, 1'b1, 4'b1000});
        vecs.push_back('{1, 4'b0001, 4'b0001, 1'b1, 4'b0001});
        vecs.push_back('{1, 4'b0101, 4'b0100, 1'b1, 4'b0100});
        vecs.push_back('{1, 4'b0001, 4'b0001, 1'b1, 4'b0001});
        vecs.push_back('{1, 4'b0000, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{1, 4'b0000, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{1, 4'b0100, 4'b0000, 1'b1, 4'b0100});

        // Reset: all outputs and ready idle while held.
        #12;
        for (int c = 0; c < 3; c++) begin
            chk("rst_valid", c, 32'(ovv[c]), 32'd0);
            chk("rst_data", c, odv[c], 32'd0);
            chk("rst_src", c, 32'(osv[c]), 32'd0);
            chk("rst_last", c, 32'(olv[c]), 32'd0);
            chk("rst_ready", c, 32'(trv[c]), 32'd0);
        end
        @(negedge clk);
        rstf = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) step(vecs[i].c, vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].etr);
        chk("cfg1_queue", 1, 32'(q.size()), 32'd1);

        // Asynchronous reset mid-packet while cfg1 is locked on ch2 with a beat held.
        #2;
        tv[1] = 4'b0000;
        rstf  = 1'b0;
        #1;
        chk("midrst_valid", 1, 32'(ovv[1]), 32'd0);
        chk("midrst_ready", 1, 32'(trv[1]), 32'd0);
        q.delete();
        @(negedge clk);
        rstf = 1'b1;
        @(negedge clk);
        step(1, 4'b0110, 4'b0110, 1'b1, 4'b0010);
        step(1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        step(1, 4'b0000, 4'b0000, 1'b1, 4'b0000);

        // cfg2: N=3 wrap 0,1,2,0,1 then search wraps from idle ptr=2 to ch0.
        step(2, 4'b0111, 4'b0111, 1'b1, 4'b0001);
        step(2, 4'b0111, 4'b0111, 1'b1, 4'b0010);
        step(2, 4'b0111, 4'b0111, 1'b1, 4'b0100);
        step(2, 4'b0111, 4'b0111, 1'b1, 4'b0001);
        step(2, 4'b0111, 4'b0111, 1'b1, 4'b0010);
        step(2, 4'b0011, 4'b0011, 1'b1, 4'b0001);
        step(2, 4'b0011, 4'b0011, 1'b1, 4'b0010);
        step(2, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        step(2, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        chk("final_queue", 2, 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
